// File: rtl/sinc3_multich_filter.sv
// Multi-channel sinc3 decimator for sigma-delta bitstreams, fully in the clk domain, with
// continuous / PWM-synchronised flush modes, data-ready IRQ pulse and per-channel overcurrent trip.
module sinc3_multich_filter #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 37,
    parameter int OUT_W  = 16,
    parameter int IRQ_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mclk,
    input  logic [NUM_CH-1:0]       mdata,
    input  logic [15:0]             dec_rate,
    input  logic [7:0]              S,
    input  logic                    sinc_mode,
    input  logic                    pwm_sync,
    input  logic [OUT_W-1:0]        trip_hi,
    input  logic [OUT_W-1:0]        trip_lo,
    input  logic [7:0]              trip_cnt_max,
    input  logic                    trip_clr,
    output logic [NUM_CH*OUT_W-1:0] data,
    output logic                    data_valid,
    output logic                    data_ready_irq,
    output logic [NUM_CH-1:0]       trip
);

    localparam int IW = $clog2(IRQ_W + 1);
    localparam logic [8:0] ACC_W_L = 9'(ACC_W);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t state_r, state_nxt_s;

    logic              mclk_s1_r, mclk_s2_r, mclk_d_r;
    logic [NUM_CH-1:0] mdata_s1_r, mdata_s2_r, x_r;
    logic              se_r;
    logic              mode_r, pwm_d_r;

    logic [ACC_W-1:0]  i1_r [NUM_CH];
    logic [ACC_W-1:0]  i2_r [NUM_CH];
    logic [ACC_W-1:0]  i3_r [NUM_CH];
    logic [ACC_W-1:0]  z1_r [NUM_CH];
    logic [ACC_W-1:0]  z2_r [NUM_CH];
    logic [ACC_W-1:0]  z3_r [NUM_CH];
    logic [ACC_W-1:0]  c1_s [NUM_CH];
    logic [ACC_W-1:0]  c2_s [NUM_CH];
    logic [ACC_W-1:0]  c3_s [NUM_CH];
    logic [OUT_W-1:0]  res_s [NUM_CH];
    logic [7:0]        trip_cnt_r [NUM_CH];
    logic [7:0]        tcnt_nxt_s [NUM_CH];

    logic [15:0]       cnt_r, rate_r, rate_in_s, cur_rate_s;
    logic              wrap_s;
    logic              cs_r;
    logic [1:0]        warm_r;

    logic              mode_chg_s, pwm_rise_s, flush_s;
    logic              int_en_s, comb_evt_s, valid_s;

    logic [NUM_CH*OUT_W-1:0] data_r;
    logic                    data_valid_r, irq_r;
    logic [IW-1:0]           irq_cnt_r;
    logic [NUM_CH-1:0]       trip_r, oow_s, trip_set_s, trip_nxt_s;
    logic [7:0]              trip_max_s;

    function automatic logic [OUT_W-1:0] shift_sat(input logic [ACC_W-1:0] v,
                                                   input logic [7:0] sh);
        logic [ACC_W-1:0] t;
        if ({1'b0, sh} >= ACC_W_L) begin
            t = {ACC_W{1'b0}};
        end else begin
            t = v >> sh;
        end
        if (|t[ACC_W-1:OUT_W]) begin
            return {OUT_W{1'b1}};
        end else begin
            return t[OUT_W-1:0];
        end
    endfunction

    // Two-stage synchroniser for mclk/mdata, rising-edge detect and sample-event generation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mclk_s1_r  <= 1'b0;
            mclk_s2_r  <= 1'b0;
            mclk_d_r   <= 1'b0;
            mdata_s1_r <= {NUM_CH{1'b0}};
            mdata_s2_r <= {NUM_CH{1'b0}};
            x_r        <= {NUM_CH{1'b0}};
            se_r       <= 1'b0;
            mode_r     <= 1'b0;
            pwm_d_r    <= 1'b0;
        end else begin
            mclk_s1_r  <= mclk;
            mclk_s2_r  <= mclk_s1_r;
            mclk_d_r   <= mclk_s2_r;
            mdata_s1_r <= mdata;
            mdata_s2_r <= mdata_s1_r;
            se_r       <= mclk_s2_r & ~mclk_d_r;
            if (mclk_s2_r && !mclk_d_r) begin
                x_r <= mdata_s2_r;
            end
            mode_r     <= sinc_mode;
            pwm_d_r    <= pwm_sync;
        end
    end

    // Flush detection, event qualification and RUN/HOLD next state
    always_comb begin
        rate_in_s   = (dec_rate < 16'd2) ? 16'd2 : dec_rate;
        cur_rate_s  = (cnt_r == 16'd0) ? rate_in_s : rate_r;
        wrap_s      = (cnt_r == (cur_rate_s - 16'd1));
        mode_chg_s  = (sinc_mode != mode_r);
        pwm_rise_s  = pwm_sync && !pwm_d_r;
        flush_s     = mode_chg_s || (sinc_mode && pwm_rise_s);
        int_en_s    = se_r && !flush_s && (state_r == RUN);
        comb_evt_s  = cs_r && !flush_s && (state_r == RUN);
        valid_s     = comb_evt_s && (warm_r == 2'd2);
        state_nxt_s = state_r;
        if (mode_chg_s) begin
            state_nxt_s = sinc_mode ? HOLD : RUN;
        end else if (flush_s) begin
            state_nxt_s = RUN;
        end else begin
            case (state_r)
                RUN:     state_nxt_s = (valid_s && sinc_mode) ? HOLD : RUN;
                HOLD:    state_nxt_s = HOLD;
                default: state_nxt_s = RUN;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Comb arithmetic, output scaling and trip-window evaluation per channel
    always_comb begin
        trip_max_s = (trip_cnt_max == 8'd0) ? 8'd1 : trip_cnt_max;
        oow_s      = {NUM_CH{1'b0}};
        trip_set_s = {NUM_CH{1'b0}};
        trip_nxt_s = {NUM_CH{1'b0}};
        for (int ch = 0; ch < NUM_CH; ch++) begin
            c1_s[ch]  = i3_r[ch] - z1_r[ch];
            c2_s[ch]  = c1_s[ch] - z2_r[ch];
            c3_s[ch]  = c2_s[ch] - z3_r[ch];
            res_s[ch] = shift_sat(c3_s[ch], S);
            oow_s[ch] = (res_s[ch] > trip_hi) || (res_s[ch] < trip_lo);
            if (!oow_s[ch]) begin
                tcnt_nxt_s[ch] = 8'd0;
            end else if (trip_cnt_r[ch] == 8'hFF) begin
                tcnt_nxt_s[ch] = 8'hFF;
            end else begin
                tcnt_nxt_s[ch] = trip_cnt_r[ch] + 8'd1;
            end
            trip_set_s[ch] = valid_s && oow_s[ch] && (tcnt_nxt_s[ch] >= trip_max_s);
            trip_nxt_s[ch] = trip_set_s[ch] || (trip_r[ch] && !trip_clr);
        end
    end

    // Integrators, decimation counter, comb delay lines and warm-up tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i1_r   <= '{default: {ACC_W{1'b0}}};
            i2_r   <= '{default: {ACC_W{1'b0}}};
            i3_r   <= '{default: {ACC_W{1'b0}}};
            z1_r   <= '{default: {ACC_W{1'b0}}};
            z2_r   <= '{default: {ACC_W{1'b0}}};
            z3_r   <= '{default: {ACC_W{1'b0}}};
            cnt_r  <= 16'd0;
            rate_r <= 16'd0;
            cs_r   <= 1'b0;
            warm_r <= 2'd0;
        end else if (flush_s) begin
            i1_r   <= '{default: {ACC_W{1'b0}}};
            i2_r   <= '{default: {ACC_W{1'b0}}};
            i3_r   <= '{default: {ACC_W{1'b0}}};
            z1_r   <= '{default: {ACC_W{1'b0}}};
            z2_r   <= '{default: {ACC_W{1'b0}}};
            z3_r   <= '{default: {ACC_W{1'b0}}};
            cnt_r  <= 16'd0;
            rate_r <= 16'd0;
            cs_r   <= 1'b0;
            warm_r <= 2'd0;
        end else begin
            cs_r <= 1'b0;
            if (int_en_s) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    i1_r[ch] <= i1_r[ch] + {{(ACC_W-1){1'b0}}, x_r[ch]};
                    i2_r[ch] <= i2_r[ch] + i1_r[ch];
                    i3_r[ch] <= i3_r[ch] + i2_r[ch];
                end
                // The ratio is captured at the start of each word so a change lands on a wrap
                if (cnt_r == 16'd0) begin
                    rate_r <= rate_in_s;
                end
                if (wrap_s) begin
                    cnt_r <= 16'd0;
                    cs_r  <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + 16'd1;
                end
            end
            if (comb_evt_s) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    z1_r[ch] <= i3_r[ch];
                    z2_r[ch] <= c1_s[ch];
                    z3_r[ch] <= c2_s[ch];
                end
                if (warm_r != 2'd2) begin
                    warm_r <= warm_r + 2'd1;
                end
            end
        end
    end

    // Output word latch, data_valid strobe, IRQ pulse stretcher and sticky trip flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r       <= {(NUM_CH*OUT_W){1'b0}};
            data_valid_r <= 1'b0;
            irq_r        <= 1'b0;
            irq_cnt_r    <= {IW{1'b0}};
            trip_r       <= {NUM_CH{1'b0}};
            trip_cnt_r   <= '{default: 8'd0};
        end else begin
            data_valid_r <= valid_s;
            trip_r       <= trip_nxt_s;
            if (valid_s) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    data_r[ch*OUT_W +: OUT_W] <= res_s[ch];
                    trip_cnt_r[ch]            <= tcnt_nxt_s[ch];
                end
                irq_r     <= 1'b1;
                irq_cnt_r <= IW'(IRQ_W - 1);
            end else if (irq_cnt_r != {IW{1'b0}}) begin
                irq_cnt_r <= irq_cnt_r - {{(IW-1){1'b0}}, 1'b1};
            end else begin
                irq_r <= 1'b0;
            end
        end
    end

    assign data           = data_r;
    assign data_valid     = data_valid_r;
    assign data_ready_irq = irq_r;
    assign trip           = trip_r;

endmodule
